// File: rtl/modular_adder_pipelined_if.sv
// Handshake bundle for modular_adder_pipelined.
// The master side presents operations and consumes results; the slave side
// is the adder. out_wrap exists only when MODULAR_ADDER_WRAP_FLAG_EN is defined.
interface modular_adder_pipelined_if #(
    parameter int WIDTH = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_add;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_err;
`ifdef MODULAR_ADDER_WRAP_FLAG_EN
    logic             out_wrap;

    modport master (
        output in_valid, in_a, in_b, in_add, out_ready,
        input  in_ready, out_valid, out_sum, out_err, out_wrap
    );

    modport slave (
        input  in_valid, in_a, in_b, in_add, out_ready,
        output in_ready, out_valid, out_sum, out_err, out_wrap
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_add, out_ready,
        input  in_ready, out_valid, out_sum, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_add, out_ready,
        output in_ready, out_valid, out_sum, out_err
    );
`endif
endinterface

// File: rtl/modular_adder_pipelined.sv
// Two-stage pipelined modular adder/subtractor.
// Stage 1 captures the raw (WIDTH+1)-bit sum or difference, the operation
// and the operand range check; stage 2 holds the corrected result and is the
// output register. Optional feature: define MODULAR_ADDER_WRAP_FLAG_EN to add
// the out_wrap flag and its pipeline register.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A presented result (out_valid high) and its data stay
// unchanged until it is transferred; in_ready never depends on in_valid.
module modular_adder_pipelined #(
    parameter int WIDTH   = 7,
    parameter int MODULUS = 26
) (
    input  logic                    clock,
    input  logic                    reset,
    modular_adder_pipelined_if.slave bus
);

    // Legal configuration: WIDTH >= 1 and 2 <= MODULUS <= 2^WIDTH.
    // For WIDTH >= 31 every positive int modulus fits below 2^WIDTH.
    generate
        if (WIDTH < 1 || MODULUS < 2 ||
            (WIDTH < 31 && MODULUS > (1 << WIDTH))) begin : g_bad_cfg
            $error("modular_adder_pipelined: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    // Modulus held in WIDTH+1 bits so that MODULUS = 2^WIDTH is exact.
    localparam logic [WIDTH:0] MOD_W = (WIDTH + 1)'(MODULUS);

    // Stage 1 registers
    logic             s1_full;
    logic [WIDTH:0]   s1_raw;
    logic             s1_add;
    logic             s1_err;

    // Stage 2 (output) registers
    logic             s2_full;
    logic [WIDTH-1:0] s2_sum;
    logic             s2_err;
`ifdef MODULAR_ADDER_WRAP_FLAG_EN
    logic             s2_wrap;
`endif

    // Control and datapath nets
    logic             s2_adv;
    logic             in_ready_w;
    logic             accept;
    logic             a_bad;
    logic             b_bad;
    logic [WIDTH:0]   raw_d;
    logic             need_corr;
    logic [WIDTH-1:0] corr;
    logic [WIDTH-1:0] res_d;

    // Stage 2 can take new data when it is empty or its result leaves now.
    assign s2_adv     = !s2_full || bus.out_ready;
    // Block input only when both stages are full and the output is stalled;
    // nothing is accepted while reset is high.
    assign in_ready_w = !reset && !(s1_full && !s2_adv);
    assign accept     = bus.in_valid && in_ready_w;

    // Stage 1 datapath: range check and raw sum/difference, carry/borrow kept.
    always_comb begin
        a_bad = ({1'b0, bus.in_a} >= MOD_W);
        b_bad = ({1'b0, bus.in_b} >= MOD_W);
        raw_d = '0;
        if (bus.in_add) begin
            raw_d = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        end else begin
            raw_d = {1'b0, bus.in_a} - {1'b0, bus.in_b};
        end
    end

    // Stage 2 datapath: correct by one modulus when the raw value wrapped.
    // A negative difference shows up as the top (borrow) bit of s1_raw.
    // The correction is exact modulo 2^WIDTH, so WIDTH bits suffice.
    always_comb begin
        need_corr = 1'b0;
        corr      = '0;
        res_d     = '0;
        if (s1_add) begin
            need_corr = (s1_raw >= MOD_W);
            corr      = s1_raw[WIDTH-1:0] - MOD_W[WIDTH-1:0];
        end else begin
            need_corr = s1_raw[WIDTH];
            corr      = s1_raw[WIDTH-1:0] + MOD_W[WIDTH-1:0];
        end
        if (s1_err) begin
            res_d = '0;
        end else if (need_corr) begin
            res_d = corr;
        end else begin
            res_d = s1_raw[WIDTH-1:0];
        end
    end

    // Stage 1 register: load on accept, drain when stage 2 takes its content.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_full <= 1'b0;
            s1_raw  <= '0;
            s1_add  <= 1'b0;
            s1_err  <= 1'b0;
        end else begin
            if (accept) begin
                s1_full <= 1'b1;
                s1_raw  <= raw_d;
                s1_add  <= bus.in_add;
                s1_err  <= a_bad || b_bad;
            end else if (s2_adv) begin
                s1_full <= 1'b0;
            end
        end
    end

    // Stage 2 register: only changes when advancing, so a stalled result holds.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_full <= 1'b0;
            s2_sum  <= '0;
            s2_err  <= 1'b0;
`ifdef MODULAR_ADDER_WRAP_FLAG_EN
            s2_wrap <= 1'b0;
`endif
        end else if (s2_adv) begin
            s2_full <= s1_full;
            if (s1_full) begin
                s2_sum  <= res_d;
                s2_err  <= s1_err;
`ifdef MODULAR_ADDER_WRAP_FLAG_EN
                s2_wrap <= need_corr && !s1_err;
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = s2_full;
    assign bus.out_sum   = s2_sum;
    assign bus.out_err   = s2_err;
`ifdef MODULAR_ADDER_WRAP_FLAG_EN
    assign bus.out_wrap  = s2_wrap;
`endif

endmodule
